// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//    Shared definitions for the generic pipeline stage register and the
//    stages that feed it.
//    - stage_state_e : occupancy encoding {skid_valid, main_valid}
//    - *_W           : packed payload widths for the ID/EX, EX/MEM and MEM/WB
//                      boundaries
//    - *_t structs   : field layouts of those payloads, MSB first
//    - *_LSB         : bit offsets of the MEM/WB fields inside the flat vector
//    - pack/unpack   : helpers converting between struct and flat vector
// ---------------------------------------------------------------------------
package pipe_pkg;

    // Occupancy of a stage. Bit 1 is the skid slot and bit 0 is the main
    // register, so the state register doubles as the two valid flags.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    // Payload widths of the individual pipeline boundaries.
    localparam int MEM_WB_W = 2 + 1 + 32 + 32 + 5 + 32;
    localparam int EX_MEM_W = 2 + 3 + 32 + 32 + 5 + 32;
    localparam int ID_EX_W  = 2 + 3 + 4 + 32 + 32 + 32 + 32 + 5 + 32;

    // MEM/WB field offsets inside the flat 104-bit vector.
    localparam int MWB_INST_LSB  = 0;
    localparam int MWB_RD_LSB    = 32;
    localparam int MWB_RDATA_LSB = 37;
    localparam int MWB_ALU_LSB   = 69;
    localparam int MWB_LOAD_BIT  = 101;
    localparam int MWB_WB_LSB    = 102;

    // EX/MEM field offsets inside the flat 106-bit vector.
    localparam int EXM_INST_LSB  = 0;
    localparam int EXM_RD_LSB    = 32;
    localparam int EXM_STORE_LSB = 37;
    localparam int EXM_ALU_LSB   = 69;
    localparam int EXM_MEM_LSB   = 101;
    localparam int EXM_WB_LSB    = 104;

    // ID/EX field offsets inside the flat 174-bit vector.
    localparam int IDX_INST_LSB  = 0;
    localparam int IDX_RD_LSB    = 32;
    localparam int IDX_IMM_LSB   = 37;
    localparam int IDX_RS2_LSB   = 69;
    localparam int IDX_RS1_LSB   = 101;
    localparam int IDX_PC_LSB    = 133;
    localparam int IDX_EX_LSB    = 165;
    localparam int IDX_MEM_LSB   = 169;
    localparam int IDX_WB_LSB    = 172;

    typedef struct packed {
        logic [1:0]  wbCtl;
        logic        isLoad;
        logic [31:0] aluResult;
        logic [31:0] memRdata;
        logic [4:0]  rdAddr;
        logic [31:0] inst;
    } mem_wb_t;

    typedef struct packed {
        logic [1:0]  wbCtl;
        logic [2:0]  memCtl;
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  rdAddr;
        logic [31:0] inst;
    } ex_mem_t;

    typedef struct packed {
        logic [1:0]  wbCtl;
        logic [2:0]  memCtl;
        logic [3:0]  exCtl;
        logic [31:0] pc;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [31:0] imm;
        logic [4:0]  rdAddr;
        logic [31:0] inst;
    } id_ex_t;

    function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input mem_wb_t f);
        return f;
    endfunction

    function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] v);
        return mem_wb_t'(v);
    endfunction

    function automatic logic [EX_MEM_W-1:0] pack_ex_mem(input ex_mem_t f);
        return f;
    endfunction

    function automatic ex_mem_t unpack_ex_mem(input logic [EX_MEM_W-1:0] v);
        return ex_mem_t'(v);
    endfunction

    function automatic logic [ID_EX_W-1:0] pack_id_ex(input id_ex_t f);
        return f;
    endfunction

    function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] v);
        return id_ex_t'(v);
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//    Generic valid/ready pipeline stage register carrying an opaque payload.
//    With SKID=1 it holds up to two beats (main register + skid slot) and its
//    in_ready comes straight from a flop; with SKID=0 it holds one beat and
//    in_ready is combinational from out_ready. Also provides a synchronous
//    flush and a saturating count of stalled output cycles.
//
// Ports
//    clk           in   1       clock, rising edge
//    reset         in   1       synchronous active-high reset
//    flush         in   1       squash all held beats (payload regs keep value)
//    in_valid      in   1       upstream beat valid
//    in_ready      out  1       stage accepts a beat this cycle
//    in_data       in   DATA_W  upstream payload
//    out_valid     out  1       downstream beat valid
//    out_ready     in   1       downstream takes the beat
//    out_data      out  DATA_W  payload presented downstream
//    stall_cycles  out  CNT_W   cycles with out_valid && !out_ready, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = MEM_WB_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cycles
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    stage_state_e      state_q;
    stage_state_e      state_d;
    logic [1:0]        stateBits;
    logic              mainValid;
    logic              skidValid;
    logic [DATA_W-1:0] mainData_q;
    logic [DATA_W-1:0] mainData_d;
    logic [DATA_W-1:0] skidData_q;
    logic              skidLoad;
    logic [CNT_W-1:0]  stallCnt_q;
    logic [CNT_W-1:0]  stallCnt_d;
    logic              acceptBeat;
    logic              consumeBeat;

    // The state encoding is {skid valid, main valid}, so the flags fall out
    // of the state register directly.
    assign stateBits   = state_q;
    assign mainValid   = stateBits[0];
    assign skidValid   = stateBits[1];

    assign out_valid    = mainValid;
    assign out_data     = mainData_q;
    assign stall_cycles = stallCnt_q;

    assign acceptBeat  = in_valid && in_ready;
    assign consumeBeat = mainValid && out_ready;

    // Next-state and main-register load. Flush empties the stage but leaves
    // payload registers untouched, and it overrides any accept or consume in
    // the same cycle. A beat arriving while the main beat is stuck goes to
    // the skid slot; when the main beat leaves from FULL, the skid beat moves
    // up so order is preserved.
    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        skidLoad   = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acceptBeat) begin
                        state_d    = ST_ONE;
                        mainData_d = in_data;
                    end
                end
                ST_ONE: begin
                    if (acceptBeat && consumeBeat) begin
                        mainData_d = in_data;
                    end else if (acceptBeat) begin
                        if (SKID != 0) begin
                            state_d  = ST_FULL;
                            skidLoad = 1'b1;
                        end
                    end else if (consumeBeat) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (consumeBeat) begin
                        state_d    = ST_ONE;
                        mainData_d = skidData_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // Stall counter: counts every cycle the downstream refuses a valid beat
    // and sticks at all-ones. Only reset clears it, so flushes do not hide
    // stall history.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (mainValid && !out_ready && (stallCnt_q != CntMax)) begin
            stallCnt_d = stallCnt_q + CntOne;
        end
    end

    // State, main payload and stall counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            mainData_q <= '0;
            stallCnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            stallCnt_q <= stallCnt_d;
        end
    end

    // Skid slot. With the slot present, in_ready is just the inverse of the
    // registered skid flag, which breaks the out_ready -> in_ready path.
    // Without it, the single register can refill in the cycle it drains.
    if (SKID != 0) begin : g_skid
        always_ff @(posedge clk) begin
            if (reset) begin
                skidData_q <= '0;
            end else if (skidLoad) begin
                skidData_q <= in_data;
            end
        end
        assign in_ready = !skidValid;
    end else begin : g_noskid
        assign skidData_q = '0;
        assign in_ready   = !mainValid || out_ready;
    end

endmodule
